// File: rtl/jaxis_jpeg_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : jaxis_jpeg_buffer
//  Description : Single-image JPEG capture buffer. Sinks the encoder's 32-bit
//                AXI-Stream output into an on-chip word RAM, reports image
//                size / done / overflow, and replays the stored image as an
//                AXI-Stream master on request.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            jpeg_clock
//    reset          synchronous, active-high reset
//    start          pulse: arm a new capture (discards the previous image)
//    read_start     pulse: replay the stored image
//    s_axis_*       capture input stream (tdata/tvalid/tready/tlast)
//    m_axis_*       replay output stream (tdata/tvalid/tready/tlast)
//    image_valid    a complete image is held in the buffer
//    image_size     stored image size in bytes (4 x stored words)
//    overflow       image was longer than DEPTH_WORDS; excess words dropped
// ============================================================================
module jaxis_jpeg_buffer #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          read_start,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    output logic [31:0]   m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic          image_valid,
    output logic [AW+2:0] image_size,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);

    state_t        r_state;
    logic [AW:0]   r_wr_ptr;      // stored word count, saturates at DEPTH_WORDS
    logic [AW:0]   r_rd_ptr;      // next word index to read from RAM
    logic          r_overflow;
    logic          r_image_valid;
    logic          r_s_tready;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rd_data;     // RAM read port register
    logic          r_rd_last;     // word in r_rd_data is the final stored word
    logic          r_inflight;    // r_rd_data holds a word due into the FIFO

    // Two-entry output FIFO; entry 0 is always the head presented on m_axis.
    logic [31:0]   r_fifo_data [2];
    logic [1:0]    r_fifo_last;
    logic [1:0]    r_count;

    logic          w_in_beat;
    logic          w_wr_en;
    logic          w_pop;
    logic [2:0]    w_level;
    logic [AW:0]   w_rd_idx;
    logic          w_rd_en;
    logic          w_rd_last;
    logic          w_last_hs;

    assign w_in_beat = s_axis_tvalid & r_s_tready;
    assign w_wr_en   = w_in_beat & (r_wr_ptr < C_DEPTH);
    assign w_pop     = (r_count != 2'd0) & m_axis_tready;

    // Occupancy the FIFO will have once the in-flight word lands and the
    // current pop retires; crediting the pop sustains one word per clock.
    assign w_level   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // The first read is issued in the read_start cycle itself so the first
    // word reaches the FIFO output two cycles after read_start.
    assign w_rd_idx  = (r_state == ST_DONE) ? '0 : r_rd_ptr;
    assign w_rd_en   = ~start &
                       (((r_state == ST_DONE) & read_start) |
                        ((r_state == ST_READOUT) & (r_rd_ptr < r_wr_ptr) &
                         (w_level < 3'd2)));
    assign w_rd_last = ((w_rd_idx + C_ONE) == r_wr_ptr);
    assign w_last_hs = w_pop & r_fifo_last[0];

    // Word RAM: synchronous write, registered read, no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_overflow     <= 1'b0;
            r_image_valid  <= 1'b0;
            r_s_tready     <= 1'b0;
            r_rd_last      <= 1'b0;
            r_inflight     <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_count        <= '0;
        end else if (start) begin
            // start overrides everything, including an in-flight replay
            r_state        <= ST_CAPTURE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_overflow     <= 1'b0;
            r_image_valid  <= 1'b0;
            r_s_tready     <= 1'b1;
            r_inflight     <= 1'b0;
            r_fifo_last    <= '0;
            r_count        <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_last <= w_rd_last;
                r_rd_ptr  <= w_rd_idx + C_ONE;
            end

            case (r_state)
                ST_CAPTURE: begin
                    if (w_in_beat) begin
                        if (r_wr_ptr < C_DEPTH) begin
                            r_wr_ptr <= r_wr_ptr + C_ONE;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        if (s_axis_tlast) begin
                            r_state       <= ST_DONE;
                            r_image_valid <= 1'b1;
                            r_s_tready    <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    if (read_start) begin
                        r_state <= ST_READOUT;
                    end
                end

                ST_READOUT: begin
                    case ({r_inflight, w_pop})
                        2'b01: begin
                            r_fifo_data[0] <= r_fifo_data[1];
                            r_fifo_last[0] <= r_fifo_last[1];
                            r_count        <= r_count - 2'd1;
                        end
                        2'b10: begin
                            if (r_count == 2'd0) begin
                                r_fifo_data[0] <= r_rd_data;
                                r_fifo_last[0] <= r_rd_last;
                            end else begin
                                r_fifo_data[1] <= r_rd_data;
                                r_fifo_last[1] <= r_rd_last;
                            end
                            r_count <= r_count + 2'd1;
                        end
                        2'b11: begin
                            if (r_count == 2'd2) begin
                                r_fifo_data[0] <= r_fifo_data[1];
                                r_fifo_last[0] <= r_fifo_last[1];
                                r_fifo_data[1] <= r_rd_data;
                                r_fifo_last[1] <= r_rd_last;
                            end else begin
                                r_fifo_data[0] <= r_rd_data;
                                r_fifo_last[0] <= r_rd_last;
                            end
                        end
                        default: ;
                    endcase
                    if (w_last_hs) begin
                        r_state <= ST_DONE;
                        r_count <= '0;
                    end
                end

                default: ;
            endcase
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = (r_count != 2'd0);
    assign m_axis_tdata  = r_fifo_data[0];
    assign m_axis_tlast  = r_fifo_last[0] & (r_count != 2'd0);
    assign image_valid   = r_image_valid;
    assign image_size    = {r_wr_ptr, 2'b00};
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_jaxis_jpeg_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jaxis_jpeg_buffer
//  Description : Self-checking bench for jaxis_jpeg_buffer (DEPTH_WORDS = 8).
//                A queue holds the words the buffer should retain; replays
//                are compared against it word by word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jaxis_jpeg_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          read_start;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          image_valid;
    logic [AW+2:0] image_size;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   img[$];          // words the buffer must hold

    always #5 clk = ~clk;

    jaxis_jpeg_buffer #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .read_start(read_start),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .image_valid(image_valid), .image_size(image_size), .overflow(overflow)
    );

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; read_start = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Capture n words; expected retained image is the first DEPTH of them.
    task automatic capture(input int n, input bit rnd, input bit gaps);
        logic [31:0]   w;
        logic [AW+2:0] exp_size;
        bit            v;
        int            k, cyc;
        img.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 2000) begin
            checks++;
            if (s_axis_tready !== 1'b1) begin
                errors++; $display("FAIL capture_tready: got %b required 1", s_axis_tready);
            end
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            w = rnd ? $urandom : 32'(k + 1) * 32'h11111111;
            s_axis_tvalid = v; s_axis_tdata = w; s_axis_tlast = (k == n - 1);
            @(posedge clk); #1;
            if (v) begin
                if (img.size() < DEPTH) img.push_back(w);
                k++;
            end
            cyc++;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        exp_size = (AW+3)'(4 * img.size());
        checks++;
        if (k < n) begin errors++; $display("FAIL capture_timeout: sent %0d required %0d", k, n); end
        checks++;
        if (image_valid !== 1'b1) begin errors++; $display("FAIL capture_image_valid: got %b required 1", image_valid); end
        checks++;
        if (image_size !== exp_size) begin errors++; $display("FAIL capture_size: got %0d required %0d", image_size, exp_size); end
        checks++;
        if (overflow !== (n > DEPTH)) begin errors++; $display("FAIL capture_overflow: got %b required %b", overflow, n > DEPTH); end
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL capture_tready_after: got %b required 0", s_axis_tready); end
    endtask

    // mode 0: tready=1, mode 1: tready 0,1,0,0,1,..., mode 2: random tready
    // with spurious read_start pulses.
    task automatic readout(input int mode);
        int          c, idx, first, n;
        bit          rdy, stalled;
        logic [31:0] prev;
        n = img.size();
        read_start = 1'b1;
        @(posedge clk); #1 read_start = 1'b0;
        c = 1; idx = 0; first = -1; stalled = 1'b0; prev = '0;
        while (idx < n && c < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((c % 3) == 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_axis_tready = rdy;
            read_start = (mode == 2) && ($urandom_range(0, 5) == 0);
            if (m_axis_tvalid === 1'b1) begin
                if (first < 0) first = c;
                checks++;
                if (m_axis_tdata !== img[idx]) begin
                    errors++; $display("FAIL replay_data[%0d]: got %h required %h", idx, m_axis_tdata, img[idx]);
                end
                checks++;
                if (m_axis_tlast !== (idx == n - 1)) begin
                    errors++; $display("FAIL replay_last[%0d]: got %b required %b", idx, m_axis_tlast, idx == n - 1);
                end
                if (stalled) begin
                    checks++;
                    if (m_axis_tdata !== prev) begin
                        errors++; $display("FAIL replay_hold: got %h required %h", m_axis_tdata, prev);
                    end
                end
                stalled = !rdy; prev = m_axis_tdata;
                if (rdy) idx++;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1; c++;
        end
        read_start = 1'b0;
        checks++;
        if (idx < n) begin errors++; $display("FAIL replay_timeout: got %0d words required %0d", idx, n); end
        checks++;
        if (first != 2) begin errors++; $display("FAIL replay_latency: got %0d required 2", first); end
        if (mode == 0) begin
            checks++;
            if (c != n + 2) begin errors++; $display("FAIL replay_throughput: ended at %0d required %0d", c, n + 2); end
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL replay_done_tvalid: got %b required 0", m_axis_tvalid); end
        checks++;
        if (image_valid !== 1'b1) begin errors++; $display("FAIL replay_image_valid: got %b required 1", image_valid); end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b required 0", s_axis_tready); end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_m_valid_last: got %b%b required 00", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_m_tdata: got %h required 0", m_axis_tdata); end
        checks++;
        if (image_valid !== 1'b0 || image_size !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_status: got valid=%b size=%0d ovf=%b required 0/0/0", image_valid, image_size, overflow);
        end
    endtask

    task automatic test_basic();
        capture(5, 1'b0, 1'b0);
        readout(0);
    endtask

    task automatic test_back_pressure();
        readout(1);
        readout(1);
    endtask

    task automatic test_overflow();
        capture(11, 1'b0, 1'b0);
        readout(0);
    endtask

    task automatic test_start_abort();
        int hs, c;
        read_start = 1'b1;
        @(posedge clk); #1 read_start = 1'b0;
        m_axis_tready = 1'b1;
        hs = 0; c = 0;
        while (hs < 2 && c < 20) begin
            if (m_axis_tvalid === 1'b1) hs++;
            @(posedge clk); #1; c++;
        end
        checks++;
        if (hs < 2) begin errors++; $display("FAIL abort_beats: got %0d required 2", hs); end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid: got %b required 0", m_axis_tvalid); end
        checks++;
        if (image_valid !== 1'b0 || image_size !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL abort_status: got valid=%b size=%0d ovf=%b required 0/0/0", image_valid, image_size, overflow);
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL abort_tready: got %b required 1", s_axis_tready); end
        m_axis_tready = 1'b0;
        capture(3, 1'b0, 1'b0);
        readout(0);
    endtask

    task automatic test_conflicts();
        do_reset();
        m_axis_tready = 1'b1;
        read_start = 1'b1;                           // ignored in IDLE
        @(posedge clk); #1 read_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
                errors++; $display("FAIL idle_read_start: got tvalid=%b tready=%b required 0/0", m_axis_tvalid, s_axis_tready);
            end
            @(posedge clk); #1;
        end
        start = 1'b1; read_start = 1'b1;             // start wins
        @(posedge clk); #1 start = 1'b0; read_start = 1'b0;
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL both_in_idle_tready: got %b required 1", s_axis_tready); end
        read_start = 1'b1;                           // ignored in CAPTURE
        @(posedge clk); #1 read_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
                errors++; $display("FAIL capture_read_start: got tvalid=%b tready=%b required 0/1", m_axis_tvalid, s_axis_tready);
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hCAFEF00D; s_axis_tlast = 1'b1;
        @(posedge clk); #1 s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        checks++;
        if (image_valid !== 1'b1 || image_size !== (AW+3)'(4)) begin
            errors++; $display("FAIL one_word_image: got valid=%b size=%0d required 1/4", image_valid, image_size);
        end
        start = 1'b1; read_start = 1'b1;             // start wins in DONE too
        @(posedge clk); #1 start = 1'b0; read_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || image_valid !== 1'b0 || image_size !== '0) begin
                errors++; $display("FAIL both_in_done: got tvalid=%b tready=%b valid=%b size=%0d required 0/1/0/0",
                                   m_axis_tvalid, s_axis_tready, image_valid, image_size);
            end
            @(posedge clk); #1;
        end
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0BADBEEF; s_axis_tlast = 1'b1;
        @(posedge clk); #1 s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        img.delete(); img.push_back(32'h0BADBEEF);
        readout(0);
    endtask

    task automatic test_reset_midstream();
        capture(6, 1'b1, 1'b0);
        read_start = 1'b1;
        @(posedge clk); #1 read_start = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_axis_tready = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || image_valid !== 1'b0 || image_size !== '0 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL midstream_reset: got tvalid=%b valid=%b size=%0d tready=%b required 0/0/0/0",
                               m_axis_tvalid, image_valid, image_size, s_axis_tready);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            capture(int'($urandom_range(1, 12)), 1'b1, 1'b1);
            readout(2);
            readout(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_basic();
        test_back_pressure();
        test_overflow();
        test_start_abort();
        test_conflicts();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
